// File: rtl/ext_bus_master.sv
// ext_bus_master
//   Peripheral bus initiator. Takes one read/write request at a time from the core over a
//   valid/ready handshake. If the address falls inside the peripheral window, it holds a bus
//   access for a fixed number of cycles. Otherwise it answers with an error and no bus access.
//   The result is returned over a valid/ready response channel.
//
// Ports
//   sys_clk, sys_rst          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready       request handshake; req_rw (1=write), req_addr, req_wdata
//   resp_valid/resp_ready     response handshake; resp_rdata, resp_err (1=outside window)
//   op, rw, addr, data_w      peripheral bus outputs (access active, direction, address, data)
//   data_r                    peripheral bus read data, sampled on the last access cycle
module ext_bus_master #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ACCESS_CYCLES = 4,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK = 32'hFFFF_0000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  op,
  output logic                  rw,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_w,
  input  logic [DATA_WIDTH-1:0] data_r
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [7:0] CntLoad = 8'(ACCESS_CYCLES - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       in_win;

  assign in_win    = (req_addr & WIN_MASK) == (WIN_BASE & WIN_MASK);
  // Only state feeds req_ready, so there is no combinational path from resp_ready.
  assign req_ready = (state_q == StIdle);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op         <= 1'b0;
      rw         <= 1'b0;
      addr       <= '0;
      data_w     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            // Latched for every request; the bus only looks at them while op is high.
            rw     <= req_rw;
            addr   <= req_addr;
            data_w <= req_wdata;
            if (in_win) begin
              cnt_q   <= CntLoad;
              op      <= 1'b1;
              state_q <= StAccess;
            end else begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state_q    <= StResp;
            end
          end
        end
        StAccess: begin
          if (cnt_q == 8'd0) begin
            op         <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= rw ? '0 : data_r;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StResp: begin
          // An error response arrives here with resp_valid still low and raises it one
          // cycle after the accept. A completed access arrives with it already high.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_master.sv
// Bench for ext_bus_master.
// Instance 0 uses ACCESS_CYCLES=4 and instance 1 uses ACCESS_CYCLES=1.
// Expected responses are queued when a request is driven and popped at the response handshake.
module tb_ext_bus_master;

  localparam logic [31:0] WinBase = 32'hF000_0000;
  localparam logic [31:0] WinMask = 32'hFFFF_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        sys_clk;
  logic        sys_rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_rw     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        op         [2];
  logic        rw         [2];
  logic [31:0] addr       [2];
  logic [31:0] data_w     [2];
  logic [31:0] data_r     [2];

  logic        exp_rw     [2];
  logic [31:0] exp_addr   [2];
  logic [31:0] exp_wd     [2];
  int          op_cnt     [2];

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;

  ext_bus_master #(.ACCESS_CYCLES(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .op(op[0]), .rw(rw[0]), .addr(addr[0]), .data_w(data_w[0]), .data_r(data_r[0])
  );

  ext_bus_master #(.ACCESS_CYCLES(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .op(op[1]), .rw(rw[1]), .addr(addr[1]), .data_w(data_w[1]), .data_r(data_r[1])
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic wr, input logic [31:0] a,
                          input logic [31:0] rd);
    exp_t e;
    logic win;
    win     = (a & WinMask) == (WinBase & WinMask);
    e.err   = !win;
    e.rdata = (win && !wr) ? rd : 32'h0;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Bus stability during op, op-cycle counting and scoreboard pops, all away from the edge.
  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (op[i]) begin
        op_cnt[i]++;
        chk("bus_rw", 64'(rw[i]), 64'(exp_rw[i]));
        chk("bus_addr", 64'(addr[i]), 64'(exp_addr[i]));
        chk("bus_data_w", 64'(data_w[i]), 64'(exp_wd[i]));
      end
      if (resp_valid[i] && resp_ready[i]) begin
        chk("sb_nonempty", 64'((i == 0) ? (q0.size() > 0) : (q1.size() > 0)), 64'd1);
        if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("resp_rdata", 64'(resp_rdata[i]), 64'(e.rdata));
          chk("resp_err", 64'(resp_err[i]), 64'(e.err));
        end
      end
    end
  end

  // Called at posedge+1 while idle; returns at posedge+1 after the accept edge.
  task automatic issue(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input bit push);
    chk("req_ready_idle", 64'(req_ready[i]), 64'd1);
    req_valid[i] = 1'b1;
    req_rw[i]    = wr;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    data_r[i]    = rd;
    exp_rw[i]    = wr;
    exp_addr[i]  = a;
    exp_wd[i]    = wd;
    if (push) push_exp(i, wr, a, rd);
    @(posedge sys_clk); #1;
    req_valid[i] = 1'b0;
    chk("req_ready_busy", 64'(req_ready[i]), 64'd0);
  endtask

  task automatic wait_resp(input int i, input int exp_lat, input int exp_op, input int op_start);
    int k;
    k = 0;
    while (!resp_valid[i] && k < 300) begin
      @(posedge sys_clk); #1;
      k++;
    end
    chk("resp_latency", 64'(k), 64'(exp_lat));
    chk("op_cycles", 64'(op_cnt[i] - op_start), 64'(exp_op));
  endtask

  task automatic consume(input int i, input int hold);
    logic [31:0] d0;
    logic        e0;
    d0 = resp_rdata[i];
    e0 = resp_err[i];
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 64'(resp_valid[i]), 64'd1);
      chk("hold_req_ready", 64'(req_ready[i]), 64'd0);
      chk("hold_rdata", 64'(resp_rdata[i]), 64'(d0));
      chk("hold_err", 64'(resp_err[i]), 64'(e0));
      @(posedge sys_clk); #1;
    end
    resp_ready[i] = 1'b1;
    @(posedge sys_clk); #1;
    resp_ready[i] = 1'b0;
    chk("post_resp_valid", 64'(resp_valid[i]), 64'd0);
    chk("post_req_ready", 64'(req_ready[i]), 64'd1);
  endtask

  initial begin
    int   s;
    int   nacc;
    int   acc_t [2];
    logic acc;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_rw[i] = 0; req_addr[i] = 0; req_wdata[i] = 0;
      resp_ready[i] = 0; data_r[i] = 0; op_cnt[i] = 0;
      exp_rw[i] = 0; exp_addr[i] = 0; exp_wd[i] = 0;
    end
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_op", 64'(op[0]), 64'd0);
    chk("rst_rw", 64'(rw[0]), 64'd0);
    chk("rst_addr", 64'(addr[0]), 64'd0);
    chk("rst_data_w", 64'(data_w[0]), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("rst_resp_err", 64'(resp_err[0]), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata[0]), 64'd0);
    chk("rst_req_ready", 64'(req_ready[0]), 64'd1);
    chk("rst_req_ready1", 64'(req_ready[1]), 64'd1);
    @(negedge sys_clk) sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    // In-window write.
    s = op_cnt[0];
    issue(0, 1'b1, 32'hF000_0004, 32'h1234_5678, 32'h5555_AAAA, 1'b1);
    wait_resp(0, 4, 4, s);
    consume(0, 0);

    // In-window read.
    s = op_cnt[0];
    issue(0, 1'b0, 32'hF000_0000, 32'h0, 32'hA1B2_C3D4, 1'b1);
    wait_resp(0, 4, 4, s);
    consume(0, 0);

    // Out-of-window read: error one cycle after the accept, no bus access.
    s = op_cnt[0];
    issue(0, 1'b0, 32'h0000_1000, 32'h0, 32'h9999_9999, 1'b1);
    wait_resp(0, 1, 0, s);
    consume(0, 0);

    // Response back-pressure with a second request already waiting.
    s = op_cnt[0];
    issue(0, 1'b0, 32'hF000_000C, 32'h0, 32'h0102_0304, 1'b1);
    wait_resp(0, 4, 4, s);
    req_valid[0] = 1'b1;
    req_rw[0]    = 1'b1;
    req_addr[0]  = 32'hF000_0010;
    req_wdata[0] = 32'h55AA_33CC;
    exp_rw[0]    = 1'b1;
    exp_addr[0]  = 32'hF000_0010;
    exp_wd[0]    = 32'h55AA_33CC;
    push_exp(0, 1'b1, 32'hF000_0010, data_r[0]);
    consume(0, 3);
    s = op_cnt[0];
    @(posedge sys_clk); #1;
    req_valid[0] = 1'b0;
    chk("second_accepted", 64'(req_ready[0]), 64'd0);
    chk("second_op", 64'(op[0]), 64'd1);
    wait_resp(0, 4, 4, s);
    consume(0, 0);

    // Reset during the second access cycle drops op at once and discards the response.
    issue(0, 1'b0, 32'hF000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0);
    @(posedge sys_clk); #1;
    chk("mid_op_before_rst", 64'(op[0]), 64'd1);
    sys_rst = 1'b0;
    #1;
    chk("async_op_drop", 64'(op[0]), 64'd0);
    chk("async_resp_valid", 64'(resp_valid[0]), 64'd0);
    @(negedge sys_clk) sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    chk("rst_rel_req_ready", 64'(req_ready[0]), 64'd1);
    chk("rst_rel_resp_valid", 64'(resp_valid[0]), 64'd0);
    s = op_cnt[0];
    issue(0, 1'b0, 32'hF000_0020, 32'h0, 32'h0BAD_F00D, 1'b1);
    wait_resp(0, 4, 4, s);
    consume(0, 0);

    // ACCESS_CYCLES=1: back-to-back write then read with resp_ready held high.
    resp_ready[1] = 1'b1;
    data_r[1]     = 32'h7766_5544;
    req_valid[1]  = 1'b1;
    req_rw[1]     = 1'b1;
    req_addr[1]   = 32'hF000_0100;
    req_wdata[1]  = 32'hCAFE_BABE;
    push_exp(1, 1'b1, 32'hF000_0100, data_r[1]);
    s    = op_cnt[1];
    nacc = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    for (int c = 0; c < 20; c++) begin
      acc = req_valid[1] && req_ready[1];
      if (acc && nacc < 2) acc_t[nacc] = c;
      @(posedge sys_clk); #1;
      if (acc && nacc < 2) begin
        exp_rw[1]   = req_rw[1];
        exp_addr[1] = req_addr[1];
        exp_wd[1]   = req_wdata[1];
        nacc++;
        if (nacc == 1) begin
          req_rw[1]    = 1'b0;
          req_addr[1]  = 32'hF000_0104;
          req_wdata[1] = 32'h1111_2222;
          push_exp(1, 1'b0, 32'hF000_0104, data_r[1]);
        end else begin
          req_valid[1] = 1'b0;
        end
      end
    end
    resp_ready[1] = 1'b0;
    chk("b2b_accepts", 64'(nacc), 64'd2);
    chk("b2b_spacing", 64'(acc_t[1] - acc_t[0]), 64'd3);
    chk("b2b_op_cycles", 64'(op_cnt[1] - s), 64'd2);

    chk("sb0_drained", 64'(q0.size()), 64'd0);
    chk("sb1_drained", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
